// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and data
// load/store. Each access is a request/done handshake toward the pipeline
// and a mem_req/mem_ready handshake toward the memory. Data wins ties, but
// once MAX_DSTREAK data grants have gone by while a fetch waited, the fetch
// goes next. A wait longer than TIMEOUT cycles is aborted with err=1.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch request and address (held until if_done)
//   if_done/if_rdata  fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata/d_be   data request (held until d_done)
//   d_done/d_rdata    data completion pulse and load data (0 on store/error)
//   err               valid with a done pulse: 1 = access timed out
//   stall_if/stall_mem  combinational stall requests to the pipeline
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request bus
//   mem_ready/mem_rdata                         memory response
module mem_port_arbiter #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_done,
   output logic [XLEN-1:0]     if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [XLEN-1:0]     d_wdata,
   input  logic [XLEN/8-1:0]   d_be,
   output logic                d_done,
   output logic [XLEN-1:0]     d_rdata,
   output logic                err,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic                mem_ready,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int BE_W = XLEN / 8;
   localparam int SW   = $clog2(MAX_DSTREAK + 1);
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
   localparam logic [TW-1:0] T_LAST     = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state, stateNext;
   logic [SW-1:0]     streak, streakNext;
   logic [TW-1:0]     tCount, tCountNext;
   logic              memReqNext, memWeNext;
   logic [ADDR_W-1:0] memAddrNext;
   logic [XLEN-1:0]   memWdataNext;
   logic [BE_W-1:0]   memBeNext;
   logic              ifDoneNext, dDoneNext, errNext;
   logic [XLEN-1:0]   ifRdataNext, dRdataNext;
   logic              dataWins;

   // Stalls are the only combinational outputs: a requester is stalled
   // until the cycle its done pulse is visible.
   assign stall_if  = if_req & ~if_done;
   assign stall_mem = d_req & ~d_done;

   // Data normally wins; a fetch that has watched MAX_DSTREAK data grants
   // in a row takes priority so it cannot be starved.
   assign dataWins = d_req & ~(if_req & (streak == STREAK_MAX));

   // Next-state and next-output logic. Every registered output holds its
   // value unless a branch below changes it, which is what keeps mem_* stable
   // during wait states and the rdata outputs stable between completions.
   always_comb begin
      stateNext    = state;
      streakNext   = streak;
      tCountNext   = tCount;
      memReqNext   = mem_req;
      memWeNext    = mem_we;
      memAddrNext  = mem_addr;
      memWdataNext = mem_wdata;
      memBeNext    = mem_be;
      ifDoneNext   = if_done;
      dDoneNext    = d_done;
      errNext      = err;
      ifRdataNext  = if_rdata;
      dRdataNext   = d_rdata;
      case (state)
         IDLE: begin
            if (dataWins) begin
               stateNext    = BUSY_D;
               memReqNext   = 1'b1;
               memWeNext    = d_we;
               memAddrNext  = d_addr;
               memWdataNext = d_wdata;
               memBeNext    = d_we ? d_be : '1;
               tCountNext   = '0;
               if (if_req && (streak != STREAK_MAX)) begin
                  streakNext = streak + 1'b1;
               end
            end else if (if_req) begin
               stateNext    = BUSY_IF;
               memReqNext   = 1'b1;
               memWeNext    = 1'b0;
               memAddrNext  = if_addr;
               memWdataNext = '0;
               memBeNext    = '1;
               tCountNext   = '0;
               streakNext   = '0;
            end
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ready) begin
               stateNext  = RESP;
               memReqNext = 1'b0;
               errNext    = 1'b0;
               if (state == BUSY_IF) begin
                  ifDoneNext  = 1'b1;
                  ifRdataNext = mem_rdata;
               end else begin
                  dDoneNext  = 1'b1;
                  dRdataNext = mem_we ? '0 : mem_rdata;
               end
            end else if ((TIMEOUT != 0) && (tCount == T_LAST)) begin
               stateNext  = RESP;
               memReqNext = 1'b0;
               errNext    = 1'b1;
               if (state == BUSY_IF) begin
                  ifDoneNext  = 1'b1;
                  ifRdataNext = '0;
               end else begin
                  dDoneNext  = 1'b1;
                  dRdataNext = '0;
               end
            end else begin
               tCountNext = tCount + 1'b1;
            end
         end
         RESP: begin
            stateNext  = IDLE;
            ifDoneNext = 1'b0;
            dDoneNext  = 1'b0;
            errNext    = 1'b0;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State and output registers. Reset aborts any access in flight without
   // a done pulse; mem_req simply drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         tCount    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         state     <= stateNext;
         streak    <= streakNext;
         tCount    <= tCountNext;
         mem_req   <= memReqNext;
         mem_we    <= memWeNext;
         mem_addr  <= memAddrNext;
         mem_wdata <= memWdataNext;
         mem_be    <= memBeNext;
         if_done   <= ifDoneNext;
         d_done    <= dDoneNext;
         err       <= errNext;
         if_rdata  <= ifRdataNext;
         d_rdata   <= dRdataNext;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (TIMEOUT overridden to 8).
// Expected memory transactions and completions are queued as stimulus is
// applied; a memory responder and a done monitor pop and compare them.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        err;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } memT;

   typedef struct {
      logic        isData;
      logic [31:0] rdata;
      logic        err;
   } respT;

   memT  memQ[$];
   respT respQ[$];
   memT  curMem;
   respT mon;

   int checkCount;
   int passCount;
   int memWait;
   bit noReady;
   int waitCnt;
   int busyCnt;
   int lastBusy;
   bit prevReq;

   mem_port_arbiter #(
      .XLEN(32), .ADDR_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of the modelled memory as a function of address.
   function automatic logic [31:0] memData(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic dReq, input logic dWe, input logic [31:0] dAddr,
                                input logic [31:0] dWdata, input logic [3:0] dBe);
      if_req  = ifReq;
      if_addr = ifAddr;
      d_req   = dReq;
      d_we    = dWe;
      d_addr  = dAddr;
      d_wdata = dWdata;
      d_be    = dBe;
   endtask

   task automatic expectFetch(input logic [31:0] a);
      memQ.push_back('{we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0});
      respQ.push_back('{isData: 1'b0, rdata: memData(a), err: 1'b0});
   endtask

   task automatic expectData(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic timedOut, input logic completes);
      memQ.push_back('{we: we, be: (we ? be : 4'hF), addr: a, wdata: wd});
      if (completes)
         respQ.push_back('{isData: 1'b1, rdata: ((we || timedOut) ? 32'h0 : memData(a)), err: timedOut});
   endtask

   // Returns at the falling edge of the n-th done pulse on the chosen port.
   task automatic waitDone(input logic isData, input int n, input string tag);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if ((isData ? d_done : if_done) === 1'b1) seen++;
      end
      if (seen < n) checkOutput({tag, "Timeout"}, 64'(seen), 64'(n));
   endtask

   // Memory responder: checks the request bus every busy cycle against the
   // expected transaction and answers after memWait wait cycles.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      prevReq   = 1'b0;
      waitCnt   = 0;
      busyCnt   = 0;
      lastBusy  = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req === 1'b1) begin
            if (!prevReq) begin
               busyCnt = 1;
               waitCnt = 0;
               if (memQ.size() == 0) begin
                  checkOutput("spuriousMemReq", 64'd1, 64'd0);
                  curMem = '{we: 1'b0, be: 4'h0, addr: 32'h0, wdata: 32'h0};
               end else begin
                  curMem = memQ.pop_front();
               end
            end else begin
               busyCnt++;
            end
            checkOutput("memAddrWdata", {mem_addr, mem_wdata}, {curMem.addr, curMem.wdata});
            checkOutput("memWeBe", {59'd0, mem_we, mem_be}, {59'd0, curMem.we, curMem.be});
            if (!noReady && waitCnt == memWait) begin
               mem_ready = 1'b1;
               mem_rdata = memData(mem_addr);
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 32'h0BAD_F00D;
               waitCnt++;
            end
            prevReq = 1'b1;
         end else begin
            if (prevReq) lastBusy = busyCnt;
            prevReq   = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 32'h0BAD_F00D;
         end
      end
   end

   // Completion monitor: every done pulse must match the next queued result.
   always @(negedge clk) begin
      if (if_done === 1'b1 || d_done === 1'b1) begin
         if (respQ.size() == 0) begin
            checkOutput("spuriousDone", 64'd1, 64'd0);
         end else begin
            mon = respQ.pop_front();
            checkOutput("donePort", {62'd0, if_done, d_done}, mon.isData ? 64'd1 : 64'd2);
            checkOutput("rdata", mon.isData ? {32'd0, d_rdata} : {32'd0, if_rdata}, {32'd0, mon.rdata});
            checkOutput("err", {63'd0, err}, {63'd0, mon.err});
         end
      end
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checkCount = 0;
      passCount  = 0;
      memWait    = 0;
      noReady    = 1'b0;

      // Reset with both requests high: nothing may leave the arbiter.
      rst = 1'b1;
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rstMemReq", {63'd0, mem_req}, 64'd0);
         checkOutput("rstMemBus", {mem_addr, mem_wdata}, 64'd0);
         checkOutput("rstFlags", {56'd0, mem_we, mem_be, if_done, d_done, err}, 64'd0);
         checkOutput("rstRdata", {if_rdata, d_rdata}, 64'd0);
      end
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Lone fetch with a single-cycle memory.
      @(posedge clk);
      #1;
      expectFetch(32'h100);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("fetchC0MemReq", {63'd0, mem_req}, 64'd0);
      checkOutput("fetchC0Stall", {63'd0, stall_if}, 64'd1);
      @(negedge clk);
      checkOutput("fetchC1MemReq", {63'd0, mem_req}, 64'd1);
      @(negedge clk);
      checkOutput("fetchC2Done", {63'd0, if_done}, 64'd1);
      checkOutput("fetchC2Stall", {63'd0, stall_if}, 64'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Store with three wait cycles.
      @(posedge clk);
      #1;
      memWait = 3;
      expectData(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011);
      @(negedge clk);
      checkOutput("storeStallMem", {63'd0, stall_mem}, 64'd1);
      waitDone(1'b1, 1, "store");
      checkOutput("storeStallMemDone", {63'd0, stall_mem}, 64'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("storeBusyLen", 64'(lastBusy), 64'd4);

      // Tie with both requests held: four data grants, then the fetch.
      @(posedge clk);
      #1;
      memWait = 0;
      for (int i = 0; i < 4; i++) expectData(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 1'b1);
      expectFetch(32'h300);
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
      waitDone(1'b0, 1, "streakFetch");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Single tie: data first, then the fetch once data drops.
      @(posedge clk);
      #1;
      expectData(1'b0, 32'h2010, 32'h0, 4'h0, 1'b0, 1'b1);
      expectFetch(32'h304);
      applyStimulus(1'b1, 32'h304, 1'b1, 1'b0, 32'h2010, 32'h0, 4'h0);
      waitDone(1'b1, 1, "pairData");
      d_req = 1'b0;
      waitDone(1'b0, 1, "pairFetch");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Timeout, then a re-sampled follow-up access from the held request.
      @(posedge clk);
      #1;
      noReady = 1'b1;
      expectData(1'b0, 32'h3000, 32'h0, 4'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0);
      waitDone(1'b1, 1, "timeout");
      checkOutput("timeoutBusyLen", 64'(lastBusy), 64'd8);
      noReady = 1'b0;
      memWait = 1;
      expectData(1'b0, 32'h3004, 32'h0, 4'h0, 1'b0, 1'b1);
      d_addr = 32'h3004;
      waitDone(1'b1, 1, "afterTimeout");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      // Build a streak of three, then reset in the middle of the third access.
      @(posedge clk);
      #1;
      memWait = 0;
      expectData(1'b0, 32'h2020, 32'h0, 4'h0, 1'b0, 1'b1);
      expectData(1'b0, 32'h2020, 32'h0, 4'h0, 1'b0, 1'b1);
      expectData(1'b0, 32'h2020, 32'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h308, 1'b1, 1'b0, 32'h2020, 32'h0, 4'h0);
      waitDone(1'b1, 2, "preReset");
      noReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midBusyMemReq", {63'd0, mem_req}, 64'd1);
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      noReady = 1'b0;
      @(negedge clk);
      checkOutput("midRstMemReq", {63'd0, mem_req}, 64'd0);
      checkOutput("midRstDone", {62'd0, d_done, err}, 64'd0);
      repeat (3) @(negedge clk);

      // Streak must restart from zero: four data grants again before the fetch.
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) expectData(1'b0, 32'h2030, 32'h0, 4'h0, 1'b0, 1'b1);
      expectFetch(32'h30C);
      applyStimulus(1'b1, 32'h30C, 1'b1, 1'b0, 32'h2030, 32'h0, 4'h0);
      waitDone(1'b0, 1, "postRstFetch");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

      repeat (5) @(negedge clk);
      checkOutput("respQEmpty", 64'(respQ.size()), 64'd0);
      checkOutput("memQEmpty", 64'(memQ.size()), 64'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
